// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the default operand width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR gate make the shared full-adder cell.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_bit_adder.sv
// Combinational 1-bit full adder shared across every bit position of the serial add.
module serial_bit_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s0),
        .c_o (c0)
    );

    half_adder u_ha1 (
        .a_i (s0),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c1)
    );

    // The two partial carries can never both be set, so OR completes the carry.
    assign c_o = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: feeds operands LSB-first through one full-adder
// cell, accumulating the sum MSB-in, with a start/busy/done handshake.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic bit_s;
    logic bit_c;

    serial_bit_adder u_cell (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (c_q),
        .s_o (bit_s),
        .c_o (bit_c)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                c_d    = bit_c;
                sum_d  = {bit_s, sum_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = bit_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
